// File: rtl/decodificador_rv32i.sv
// -----------------------------------------------------------------------------
// decodificador_rv32i
//
// RV32I decode stage. It sits in front of a 32x32 register file whose read is
// synchronous. It accepts one instruction per cycle from fetch and drives both
// register-file read ports on the acceptance edge. One cycle later it presents
// the operands, the sign-extended immediate and the decoded fields to execute
// from a one-entry holding register (B).
//
// Optional feature (macro DECOD_BYPASS_WB_EN):
//   defined   - writeback bypass. A write on the acceptance edge, or any later
//               write while B stalls, replaces the stale register-file data.
//   undefined - operands come straight from the register file.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   ent_valido/ent_listo      fetch handshake
//   ent_instr, ent_pc         incoming instruction and its PC
//   rf_hab_r1/2, rf_addr_r1/2 register-file read enables / addresses
//   rf_data_r1/2              registered register-file read data
//   wb_hab, wb_addr, wb_data  copy of the register-file write port
//   vaciar                    synchronous flush of B
//   sal_valido/sal_listo      execute handshake
//   sal_pc, sal_rs1_val, sal_rs2_val, sal_imm, sal_rd, sal_opcode,
//   sal_funct3, sal_funct7b5, sal_ilegal   decoded outputs
// -----------------------------------------------------------------------------
module decodificador_rv32i #(
    parameter int ANCHO_PC = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ent_valido,
    output logic                ent_listo,
    input  logic [31:0]         ent_instr,
    input  logic [ANCHO_PC-1:0] ent_pc,
    output logic                rf_hab_r1,
    output logic                rf_hab_r2,
    output logic [4:0]          rf_addr_r1,
    output logic [4:0]          rf_addr_r2,
    input  logic [31:0]         rf_data_r1,
    input  logic [31:0]         rf_data_r2,
    input  logic                wb_hab,
    input  logic [4:0]          wb_addr,
    input  logic [31:0]         wb_data,
    input  logic                vaciar,
    output logic                sal_valido,
    input  logic                sal_listo,
    output logic [ANCHO_PC-1:0] sal_pc,
    output logic [31:0]         sal_rs1_val,
    output logic [31:0]         sal_rs2_val,
    output logic [31:0]         sal_imm,
    output logic [4:0]          sal_rd,
    output logic [6:0]          sal_opcode,
    output logic [2:0]          sal_funct3,
    output logic                sal_funct7b5,
    output logic                sal_ilegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Sign-extended immediate selected by instruction format.
    function automatic logic [31:0] gen_imm(input logic [31:0] i);
        logic [31:0] r;
        case (i[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM:
                r = {{20{i[31]}}, i[31:20]};
            OP_STORE:
                r = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:
                r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                r = {i[31:12], 12'd0};
            OP_JAL:
                r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                r = 32'd0;  // OP, FENCE and illegal encodings
        endcase
        return r;
    endfunction

    // True for the 11 RV32I base opcodes with the 32-bit length marker.
    function automatic logic es_legal(input logic [31:0] i);
        logic r;
        case (i[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM:
                r = 1'b1;
            default:
                r = 1'b0;
        endcase
        return r & (i[1:0] == 2'b11);
    endfunction

    logic b_valido_r;
    logic acepta_s;

    // ent_listo has no path from ent_valido; it only looks at B and execute.
    assign ent_listo  = rst & ~vaciar & (~b_valido_r | sal_listo);
    assign acepta_s   = ent_valido & ent_listo;
    assign rf_hab_r1  = acepta_s;
    assign rf_hab_r2  = acepta_s;
    assign sal_valido = b_valido_r;

    // Read addresses: unused operands point at x0 so they read as zero.
    always_comb begin
        rf_addr_r1 = ent_instr[19:15];
        rf_addr_r2 = 5'd0;
        case (ent_instr[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: begin
                rf_addr_r1 = 5'd0;
                rf_addr_r2 = 5'd0;
            end
            OP_BRANCH, OP_STORE, OP_OP: begin
                rf_addr_r1 = ent_instr[19:15];
                rf_addr_r2 = ent_instr[24:20];
            end
            default: begin
                rf_addr_r1 = ent_instr[19:15];
                rf_addr_r2 = 5'd0;
            end
        endcase
    end

    // Holding register B: valid flag and all registered decoded fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_valido_r   <= 1'b0;
            sal_pc       <= '0;
            sal_imm      <= 32'd0;
            sal_rd       <= 5'd0;
            sal_opcode   <= 7'd0;
            sal_funct3   <= 3'd0;
            sal_funct7b5 <= 1'b0;
            sal_ilegal   <= 1'b0;
        end else if (vaciar) begin
            b_valido_r <= 1'b0;
        end else if (acepta_s) begin
            // Also covers accept-and-depart on the same edge: B is replaced.
            b_valido_r   <= 1'b1;
            sal_pc       <= ent_pc;
            sal_imm      <= gen_imm(ent_instr);
            sal_rd       <= ((ent_instr[6:0] == OP_BRANCH) || (ent_instr[6:0] == OP_STORE))
                            ? 5'd0 : ent_instr[11:7];
            sal_opcode   <= ent_instr[6:0];
            sal_funct3   <= ent_instr[14:12];
            sal_funct7b5 <= ent_instr[30];
            sal_ilegal   <= ~es_legal(ent_instr);
        end else if (sal_listo) begin
            b_valido_r <= 1'b0;
        end else begin
            b_valido_r <= b_valido_r;
        end
    end

`ifdef DECOD_BYPASS_WB_EN
    logic        fwd1_r;
    logic        fwd2_r;
    logic [31:0] fwd_dato1_r;
    logic [31:0] fwd_dato2_r;
    logic [4:0]  rs1_r;
    logic [4:0]  rs2_r;

    // Bypass registers: catch the same-edge write the registered read misses,
    // then keep tracking writes to rs1/rs2 while B stalls (latest wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd1_r      <= 1'b0;
            fwd2_r      <= 1'b0;
            fwd_dato1_r <= 32'd0;
            fwd_dato2_r <= 32'd0;
            rs1_r       <= 5'd0;
            rs2_r       <= 5'd0;
        end else if (vaciar) begin
            fwd1_r <= 1'b0;
            fwd2_r <= 1'b0;
        end else if (acepta_s) begin
            rs1_r       <= rf_addr_r1;
            rs2_r       <= rf_addr_r2;
            fwd1_r      <= wb_hab & (wb_addr == rf_addr_r1) & (wb_addr != 5'd0);
            fwd2_r      <= wb_hab & (wb_addr == rf_addr_r2) & (wb_addr != 5'd0);
            fwd_dato1_r <= wb_data;
            fwd_dato2_r <= wb_data;
        end else if (b_valido_r && !sal_listo) begin
            if (wb_hab && (wb_addr == rs1_r) && (wb_addr != 5'd0)) begin
                fwd1_r      <= 1'b1;
                fwd_dato1_r <= wb_data;
            end
            if (wb_hab && (wb_addr == rs2_r) && (wb_addr != 5'd0)) begin
                fwd2_r      <= 1'b1;
                fwd_dato2_r <= wb_data;
            end
        end else begin
            fwd1_r <= 1'b0;
            fwd2_r <= 1'b0;
        end
    end

    assign sal_rs1_val = !rst ? 32'd0 : (fwd1_r ? fwd_dato1_r : rf_data_r1);
    assign sal_rs2_val = !rst ? 32'd0 : (fwd2_r ? fwd_dato2_r : rf_data_r2);
`else
    // Without the bypass the writeback port is only observed, never used.
    logic unused_wb_s;
    assign unused_wb_s = ^{wb_hab, wb_addr, wb_data};

    assign sal_rs1_val = !rst ? 32'd0 : rf_data_r1;
    assign sal_rs2_val = !rst ? 32'd0 : rf_data_r2;
`endif

endmodule

// File: tb/tb_decodificador_rv32i.sv
// -----------------------------------------------------------------------------
// tb_decodificador_rv32i
//
// Directed bench for decodificador_rv32i. A small register-file model sits on
// the read/write ports. Expected outputs are pushed to a scoreboard queue on
// each acceptance edge and retired when B departs or is flushed.
// -----------------------------------------------------------------------------
module tb_decodificador_rv32i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ent_valido, ent_listo;
    logic [31:0] ent_instr, ent_pc;
    logic        rf_hab_r1, rf_hab_r2;
    logic [4:0]  rf_addr_r1, rf_addr_r2;
    logic [31:0] rf_data_r1 = 32'd0, rf_data_r2 = 32'd0;
    logic        wb_hab;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        vaciar;
    logic        sal_valido, sal_listo;
    logic [31:0] sal_pc, sal_rs1_val, sal_rs2_val, sal_imm;
    logic [4:0]  sal_rd;
    logic [6:0]  sal_opcode;
    logic [2:0]  sal_funct3;
    logic        sal_funct7b5, sal_ilegal;

    logic [31:0] rf_mem [32];
    exp_t        sb[$];
    exp_t        nxt;
    exp_t        tmp;
    int          n_eval = 0;
    int          n_fail = 0;
    int          n_acc  = 0;
    int          hab1_cnt = 0;
    int          hab2_cnt = 0;

    decodificador_rv32i #(.ANCHO_PC(32)) dut (
        .clk(clk), .rst(rst),
        .ent_valido(ent_valido), .ent_listo(ent_listo),
        .ent_instr(ent_instr), .ent_pc(ent_pc),
        .rf_hab_r1(rf_hab_r1), .rf_hab_r2(rf_hab_r2),
        .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2),
        .wb_hab(wb_hab), .wb_addr(wb_addr), .wb_data(wb_data),
        .vaciar(vaciar),
        .sal_valido(sal_valido), .sal_listo(sal_listo),
        .sal_pc(sal_pc), .sal_rs1_val(sal_rs1_val), .sal_rs2_val(sal_rs2_val),
        .sal_imm(sal_imm), .sal_rd(sal_rd), .sal_opcode(sal_opcode),
        .sal_funct3(sal_funct3), .sal_funct7b5(sal_funct7b5),
        .sal_ilegal(sal_ilegal)
    );

    always #5 clk = ~clk;

    // Register-file model: registered read, write visible to later reads only.
    always @(posedge clk) begin
        if (rf_hab_r1) rf_data_r1 <= rf_mem[rf_addr_r1];
        if (rf_hab_r2) rf_data_r2 <= rf_mem[rf_addr_r2];
        if (wb_hab && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
        if (rf_hab_r1) hab1_cnt <= hab1_cnt + 1;
        if (rf_hab_r2) hab2_cnt <= hab2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_eval++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: record acceptance/departure as seen before the edge.
    task automatic tick();
        logic acc, dep;
        acc = ent_valido && ent_listo;
        dep = sal_valido && (sal_listo || vaciar);
        @(posedge clk);
        #1;
        if (dep && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            sb.push_back(nxt);
            n_acc++;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valido"}, {31'd0, sal_valido}, {31'd0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            chk({tag, ".pc"},  sal_pc,      sb[0].pc);
            chk({tag, ".rs1"}, sal_rs1_val, sb[0].rs1);
            chk({tag, ".rs2"}, sal_rs2_val, sb[0].rs2);
            chk({tag, ".imm"}, sal_imm,     sb[0].imm);
            chk({tag, ".rd"},  {27'd0, sal_rd},       {27'd0, sb[0].rd});
            chk({tag, ".op"},  {25'd0, sal_opcode},   {25'd0, sb[0].op});
            chk({tag, ".f3"},  {29'd0, sal_funct3},   {29'd0, sb[0].f3});
            chk({tag, ".f7"},  {31'd0, sal_funct7b5}, {31'd0, sb[0].f7});
            chk({tag, ".il"},  {31'd0, sal_ilegal},   {31'd0, sb[0].il});
        end
    endtask

    logic [31:0] str_i [4];
    exp_t        str_e [4];
    logic [31:0] rs2_add;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0000_1000 + i;
        rf_mem[0] = 32'd0;
        rf_mem[1] = 32'h0000_0011;
        rf_mem[2] = 32'h0000_0022;
`ifdef DECOD_BYPASS_WB_EN
        rs2_add = 32'h0000_00AB;
`else
        rs2_add = 32'h0000_0022;
`endif
        rst = 1'b0; ent_valido = 1'b0; ent_instr = 32'd0; ent_pc = 32'd0;
        wb_hab = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; vaciar = 1'b0; sal_listo = 1'b0;

        // Reset state
        #2;
        chk("rst.ent_listo", {31'd0, ent_listo}, 32'd0);
        chk("rst.rf_hab",    {31'd0, rf_hab_r1}, 32'd0);
        chk("rst.valido",    {31'd0, sal_valido}, 32'd0);
        tick();
        rst = 1'b1;
        settle();

        // addi x5,x0,-3
        ent_valido = 1'b1; ent_instr = 32'hFFD0_0293; ent_pc = 32'h0000_0100;
        nxt = '{32'h100, 32'd0, 32'd0, 32'hFFFF_FFFD, 5'd5, 7'h13, 3'd0, 1'b1, 1'b0};
        settle();
        chk("addi.ent_listo", {31'd0, ent_listo}, 32'd1);
        chk("addi.rf_hab",    {31'd0, rf_hab_r1}, 32'd1);
        chk("addi.addr1",     {27'd0, rf_addr_r1}, 32'd0);
        chk("addi.addr2",     {27'd0, rf_addr_r2}, 32'd0);
        tick();
        ent_valido = 1'b0; sal_listo = 1'b1;
        settle();
        check_out("addi");
        tick();

        // add x3,x1,x2 with same-edge writeback x2=0xAB
        ent_valido = 1'b1; ent_instr = 32'h0020_81B3; ent_pc = 32'h0000_0104;
        wb_hab = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_00AB; sal_listo = 1'b0;
        nxt = '{32'h104, 32'h11, rs2_add, 32'd0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b0};
        settle();
        chk("add.addr1", {27'd0, rf_addr_r1}, 32'd1);
        chk("add.addr2", {27'd0, rf_addr_r2}, 32'd2);
        tick();

        // Stall cycle 1: fetch offers a nop that must not be taken
        ent_instr = 32'h0000_0013; wb_hab = 1'b0;
        settle();
        check_out("stall1");
        chk("stall1.ent_listo", {31'd0, ent_listo}, 32'd0);
        chk("stall1.rf_hab",    {31'd0, rf_hab_r1}, 32'd0);
        tick();
        // Stall cycle 2: writeback x1=0x55
        wb_hab = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000_0055;
        settle();
        check_out("stall2");
        tick();
        // Stall cycle 3: rs1 now forwarded (stays at old x1 without bypass)
        wb_hab = 1'b0;
        tmp = sb[0];
`ifdef DECOD_BYPASS_WB_EN
        tmp.rs1 = 32'h0000_0055;
`endif
        sb[0] = tmp;
        settle();
        check_out("stall3");

        // Back-to-back stream: lui, sw, jal, beq -8
        str_i[0] = 32'h1234_53B7;
        str_e[0] = '{32'h200, 32'd0, 32'd0, 32'h1234_5000, 5'd7, 7'h37, 3'd5, 1'b0, 1'b0};
        str_i[1] = 32'h0020_A623;
        str_e[1] = '{32'h204, 32'h55, 32'hAB, 32'h0000_000C, 5'd0, 7'h23, 3'd2, 1'b0, 1'b0};
        str_i[2] = 32'h0100_00EF;
        str_e[2] = '{32'h208, 32'd0, 32'd0, 32'h0000_0010, 5'd1, 7'h6F, 3'd0, 1'b0, 1'b0};
        str_i[3] = 32'hFE00_0CE3;
        str_e[3] = '{32'h20C, 32'd0, 32'd0, 32'hFFFF_FFF8, 5'd0, 7'h63, 3'd0, 1'b1, 1'b0};
        sal_listo = 1'b1;
        ent_instr = str_i[0]; ent_pc = 32'h200; nxt = str_e[0];
        settle();
        tick();
        for (int k = 1; k < 4; k++) begin
            ent_instr = str_i[k]; ent_pc = 32'h200 + 32'(k * 4); nxt = str_e[k];
            settle();
            check_out($sformatf("stream%0d", k - 1));
            tick();
        end

        // Illegal opcode follows immediately behind the beq
        ent_instr = 32'h0000_007F; ent_pc = 32'h210;
        nxt = '{32'h210, 32'd0, 32'd0, 32'd0, 5'd0, 7'h7F, 3'd0, 1'b0, 1'b1};
        settle();
        check_out("stream3");
        tick();
        ent_valido = 1'b0; sal_listo = 1'b0;
        settle();
        check_out("ilegal");
        tick();

        // Flush while B is valid
        vaciar = 1'b1; ent_valido = 1'b1; ent_instr = 32'hFFD0_0293;
        settle();
        chk("vaciar.ent_listo", {31'd0, ent_listo}, 32'd0);
        chk("vaciar.rf_hab",    {31'd0, rf_hab_r1}, 32'd0);
        tick();
        vaciar = 1'b0; ent_valido = 1'b0;
        settle();
        check_out("vaciar");

        // Asynchronous reset in the middle of a stall
        ent_valido = 1'b1; ent_pc = 32'h300;
        nxt = '{32'h300, 32'd0, 32'd0, 32'hFFFF_FFFD, 5'd5, 7'h13, 3'd0, 1'b1, 1'b0};
        settle();
        tick();
        ent_valido = 1'b0;
        settle();
        check_out("pre_rst");
        ent_valido = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        sb.delete();
        chk("arst.valido",    {31'd0, sal_valido}, 32'd0);
        chk("arst.pc",        sal_pc, 32'd0);
        chk("arst.imm",       sal_imm, 32'd0);
        chk("arst.rd",        {27'd0, sal_rd}, 32'd0);
        chk("arst.op",        {25'd0, sal_opcode}, 32'd0);
        chk("arst.f7",        {31'd0, sal_funct7b5}, 32'd0);
        chk("arst.rs1",       sal_rs1_val, 32'd0);
        chk("arst.ent_listo", {31'd0, ent_listo}, 32'd0);
        chk("arst.rf_hab",    {31'd0, rf_hab_r1}, 32'd0);
        ent_valido = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("post.ent_listo", {31'd0, ent_listo}, 32'd1);
        chk("hab1.count", 32'(hab1_cnt), 32'(n_acc));
        chk("hab2.count", 32'(hab2_cnt), 32'(n_acc));
        chk("acc.count",  32'(n_acc), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
